// File: rtl/spu_pkg.sv
// Shared definitions for the SPU controller: opcodes, FSM state encodings and
// the register-file write mux / ALU select codes driven onto the datapath.
package spu_pkg;

    localparam logic [3:0] OP_LOAD  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_LDC   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_JMPZ  = 4'h5;
    localparam logic [3:0] OP_HALT  = 4'h6;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_FETCH      = 4'd1,
        ST_DECODE     = 4'd2,
        ST_LOAD       = 4'd3,
        ST_STORE      = 4'd4,
        ST_ALU        = 4'd5,
        ST_LDC        = 4'd6,
        ST_JMPZ       = 4'd7,
        ST_JMPZ_TAKEN = 4'd8,
        ST_HALT       = 4'd9,
        ST_TRAP       = 4'd10
    } state_e;

    localparam logic [1:0] RF_SEL_ALU  = 2'b00;
    localparam logic [1:0] RF_SEL_DM   = 2'b01;
    localparam logic [1:0] RF_SEL_LOAC = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;

    function automatic logic [3:0] ir_op(input logic [15:0] ir);
        return ir[15:12];
    endfunction

endpackage

// File: rtl/spu_ack_timer.sv
// Counts cycles a memory strobe has been held without an ack; expired_o marks
// the last cycle in which an ack is still accepted.
module spu_ack_timer #(
    parameter int ACK_TMO = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);

    localparam int CW = (ACK_TMO < 2) ? 1 : $clog2(ACK_TMO);
    localparam logic [CW-1:0] LIMIT = CW'(ACK_TMO - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst || clear_i) begin
            cnt_q <= '0;
        end else if (count_en_i && !expired_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // cnt_q equals the number of already-elapsed unacked cycles
    assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/spu_ctrl_p.sv
// SPU control unit: fetch/decode/execute FSM driving instruction memory, data
// memory and register-file controls. Handshake: a strobe (im_rd, dm_rd, dm_wr)
// stays high until its ack is seen at a rising edge; that edge completes it.
module spu_ctrl_p
    import spu_pkg::*;
#(
    parameter int IM_AW   = 8,
    parameter int DM_AW   = 8,
    parameter int ACK_TMO = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             stop,
    output logic             trap,
    input  logic [15:0]      im_r_data,
    input  logic             im_ack,
    output logic [IM_AW-1:0] im_addr,
    output logic             im_rd,
    output logic [DM_AW-1:0] dm_addr,
    output logic             dm_rd,
    output logic             dm_wr,
    input  logic             dm_ack,
    output logic             rf_s1,
    output logic             rf_s0,
    output logic [3:0]       rf_w_addr,
    output logic [3:0]       rf_rp_addr,
    output logic [3:0]       rf_rq_addr,
    output logic             rf_w_wr,
    output logic             rf_rp_rd,
    output logic             rf_rq_rd,
    input  logic             rp_zero,
    output logic             alu_s1,
    output logic             alu_s0,
    output logic [7:0]       loac,
    output logic [3:0]       dbg_state_o
);

    typedef struct packed {
        logic             stop;
        logic             trap;
        logic             im_rd;
        logic             dm_rd;
        logic             dm_wr;
        logic [1:0]       rf_s;
        logic [3:0]       w_addr;
        logic [3:0]       rp_addr;
        logic [3:0]       rq_addr;
        logic             w_wr;
        logic             rp_rd;
        logic             rq_rd;
        logic [1:0]       alu;
        logic [7:0]       loac;
        logic [DM_AW-1:0] dm_addr;
    } ctrl_t;

    function automatic ctrl_t ctrl_for(input state_e s, input logic [15:0] ir);
        ctrl_t c;
        c = '0;
        case (s)
            ST_IDLE, ST_HALT: c.stop = 1'b1;
            ST_TRAP: begin
                c.stop = 1'b1;
                c.trap = 1'b1;
            end
            ST_FETCH: c.im_rd = 1'b1;
            ST_LOAD: begin
                c.dm_rd   = 1'b1;
                c.rf_s    = RF_SEL_DM;
                c.w_addr  = ir[11:8];
                c.dm_addr = ir[DM_AW-1:0];
            end
            ST_STORE: begin
                c.dm_wr   = 1'b1;
                c.rp_rd   = 1'b1;
                c.rp_addr = ir[11:8];
                c.dm_addr = ir[DM_AW-1:0];
            end
            ST_ALU: begin
                c.rp_rd   = 1'b1;
                c.rq_rd   = 1'b1;
                c.rp_addr = ir[7:4];
                c.rq_addr = ir[3:0];
                c.alu     = (ir_op(ir) == OP_SUB) ? ALU_SUB : ALU_ADD;
                c.rf_s    = RF_SEL_ALU;
                c.w_wr    = 1'b1;
                c.w_addr  = ir[11:8];
            end
            ST_LDC: begin
                c.loac   = ir[7:0];
                c.rf_s   = RF_SEL_LOAC;
                c.w_wr   = 1'b1;
                c.w_addr = ir[11:8];
            end
            ST_JMPZ: begin
                c.rp_rd   = 1'b1;
                c.rp_addr = ir[11:8];
            end
            default: ;
        endcase
        return c;
    endfunction

    state_e           state_q, state_d;
    logic [IM_AW-1:0] pc_q, pc_d;
    logic [15:0]      ir_q, ir_d;
    ctrl_t            ctrl_q;
    logic             wait_en;
    logic             ack_now;
    logic             expired;

    assign ack_now = (state_q == ST_FETCH) ? im_ack : dm_ack;

    spu_ack_timer #(
        .ACK_TMO(ACK_TMO)
    ) u_ack_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (!wait_en || ack_now),
        .count_en_i(wait_en && !ack_now),
        .expired_o (expired)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        wait_en = 1'b0;
        case (state_q)
            ST_IDLE, ST_TRAP: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end
            ST_HALT: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                wait_en = 1'b1;
                if (im_ack) begin
                    ir_d    = im_r_data;
                    pc_d    = pc_q + 1'b1;
                    state_d = ST_DECODE;
                end else if (expired) begin
                    state_d = ST_TRAP;
                end
            end
            ST_DECODE: begin
                case (ir_op(ir_q))
                    OP_LOAD:        state_d = ST_LOAD;
                    OP_STORE:       state_d = ST_STORE;
                    OP_ADD, OP_SUB: state_d = ST_ALU;
                    OP_LDC:         state_d = ST_LDC;
                    OP_JMPZ:        state_d = ST_JMPZ;
                    OP_HALT:        state_d = ST_HALT;
                    default:        state_d = ST_TRAP;
                endcase
            end
            ST_LOAD, ST_STORE: begin
                wait_en = 1'b1;
                if (dm_ack) begin
                    state_d = ST_FETCH;
                end else if (expired) begin
                    state_d = ST_TRAP;
                end
            end
            ST_ALU, ST_LDC: state_d = ST_FETCH;
            ST_JMPZ: state_d = rp_zero ? ST_JMPZ_TAKEN : ST_FETCH;
            ST_JMPZ_TAKEN: begin
                // low IM_AW bits of the sign-extended offset suffice modulo 2^IM_AW
                pc_d    = pc_q + ir_q[IM_AW-1:0] - 1'b1;
                state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            ctrl_q  <= ctrl_for(ST_IDLE, 16'h0000);
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ctrl_q  <= ctrl_for(state_d, ir_d);
        end
    end

    assign stop        = ctrl_q.stop;
    assign trap        = ctrl_q.trap;
    assign im_addr     = pc_q;
    assign im_rd       = ctrl_q.im_rd;
    assign dm_addr     = ctrl_q.dm_addr;
    assign dm_rd       = ctrl_q.dm_rd;
    assign dm_wr       = ctrl_q.dm_wr;
    assign rf_s1       = ctrl_q.rf_s[1];
    assign rf_s0       = ctrl_q.rf_s[0];
    assign rf_w_addr   = ctrl_q.w_addr;
    assign rf_rp_addr  = ctrl_q.rp_addr;
    assign rf_rq_addr  = ctrl_q.rq_addr;
    // a LOAD writes the register file only in the cycle the read data is valid
    assign rf_w_wr     = ctrl_q.w_wr || (state_q == ST_LOAD && dm_ack);
    assign rf_rp_rd    = ctrl_q.rp_rd;
    assign rf_rq_rd    = ctrl_q.rq_rd;
    assign alu_s1      = ctrl_q.alu[1];
    assign alu_s0      = ctrl_q.alu[0];
    assign loac        = ctrl_q.loac;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spu_ctrl_p.sv
// Directed bench for spu_ctrl_p (IM_AW=4): memory responders with programmable
// ack latency, plus scoreboards for fetch addresses, decode-time PC and rf writes.
module tb_spu_ctrl_p;
    import spu_pkg::*;

    logic        clk, rst, start, stop, trap;
    logic [15:0] im_r_data;
    logic        im_ack, im_rd, dm_rd, dm_wr, dm_ack;
    logic [3:0]  im_addr;
    logic [7:0]  dm_addr, loac;
    logic        rf_s1, rf_s0, rf_w_wr, rf_rp_rd, rf_rq_rd, rp_zero, alu_s1, alu_s0;
    logic [3:0]  rf_w_addr, rf_rp_addr, rf_rq_addr, dbg_state;

    spu_ctrl_p #(.IM_AW(4), .DM_AW(8), .ACK_TMO(15)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .trap(trap),
        .im_r_data(im_r_data), .im_ack(im_ack), .im_addr(im_addr), .im_rd(im_rd),
        .dm_addr(dm_addr), .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_ack(dm_ack),
        .rf_s1(rf_s1), .rf_s0(rf_s0), .rf_w_addr(rf_w_addr), .rf_rp_addr(rf_rp_addr),
        .rf_rq_addr(rf_rq_addr), .rf_w_wr(rf_w_wr), .rf_rp_rd(rf_rp_rd),
        .rf_rq_rd(rf_rq_rd), .rp_zero(rp_zero), .alu_s1(alu_s1), .alu_s0(alu_s0),
        .loac(loac), .dbg_state_o(dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;

    logic [15:0] imem [16];
    int          im_lat = 0;
    int          dm_lat = 0;
    logic [15:0] zero_mask = 16'h0001;
    assign rp_zero = zero_mask[rf_rp_addr];

    logic [3:0]  exp_fetch_q[$];
    logic [3:0]  exp_pc_q[$];
    logic [25:0] exp_wr_q[$];
    bit          pc_mon_en = 1'b0;

    int          im_rd_cyc, dm_rd_cyc, dm_wr_cyc, wr_pulses, dm_addr_bad, store_bad, both_bad;
    logic [7:0]  exp_dm;
    logic [3:0]  exp_rp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [25:0] desc(input logic [3:0] wa, input logic [1:0] s,
                                         input logic [1:0] alu, input logic [7:0] lc,
                                         input logic prd, input logic [3:0] pa,
                                         input logic qrd, input logic [3:0] qa);
        return {wa, s, alu, lc, prd, pa, qrd, qa};
    endfunction

    // memory responders: ack after *_lat unacked cycles of the strobe
    initial begin
        int cnt;
        cnt = 0;
        im_ack = 1'b0;
        im_r_data = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (im_rd && cnt >= im_lat) begin
                im_ack = 1'b1;
                im_r_data = imem[im_addr];
                cnt = 0;
            end else begin
                im_ack = 1'b0;
                im_r_data = 16'h0000;
                cnt = im_rd ? cnt + 1 : 0;
            end
        end
    end

    initial begin
        int cnt;
        cnt = 0;
        dm_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if ((dm_rd || dm_wr) && cnt >= dm_lat) begin
                dm_ack = 1'b1;
                cnt = 0;
            end else begin
                dm_ack = 1'b0;
                cnt = (dm_rd || dm_wr) ? cnt + 1 : 0;
            end
        end
    end

    // scoreboard monitors
    initial begin
        forever begin
            @(negedge clk);
            if (im_rd && im_ack) begin
                if (exp_fetch_q.size() == 0) chk("fetch_unexpected", {28'h0, im_addr}, 32'hFFFF_FFFF);
                else chk("fetch_addr", {28'h0, im_addr}, {28'h0, exp_fetch_q.pop_front()});
            end
            if (rf_w_wr) begin
                wr_pulses++;
                if (exp_wr_q.size() == 0) chk("rf_wr_unexpected", {6'h0, desc(rf_w_addr, {rf_s1, rf_s0},
                    {alu_s1, alu_s0}, loac, rf_rp_rd, rf_rp_addr, rf_rq_rd, rf_rq_addr)}, 32'hFFFF_FFFF);
                else chk("rf_wr", {6'h0, desc(rf_w_addr, {rf_s1, rf_s0}, {alu_s1, alu_s0}, loac,
                    rf_rp_rd, rf_rp_addr, rf_rq_rd, rf_rq_addr)}, {6'h0, exp_wr_q.pop_front()});
            end
            if (pc_mon_en && dbg_state == ST_DECODE) begin
                if (exp_pc_q.size() == 0) chk("pc_unexpected", {28'h0, im_addr}, 32'hFFFF_FFFF);
                else chk("decode_pc", {28'h0, im_addr}, {28'h0, exp_pc_q.pop_front()});
            end
            if (im_rd) im_rd_cyc++;
            if (dm_rd) dm_rd_cyc++;
            if (dm_wr) dm_wr_cyc++;
            if (dm_rd && dm_wr) both_bad++;
            if ((dm_rd || dm_wr) && dm_addr != exp_dm) dm_addr_bad++;
            if (dm_wr && (!rf_rp_rd || rf_rp_addr != exp_rp)) store_bad++;
        end
    end

    // driver tasks
    task automatic clear_stats();
        im_rd_cyc = 0; dm_rd_cyc = 0; dm_wr_cyc = 0; wr_pulses = 0;
        dm_addr_bad = 0; store_bad = 0; both_bad = 0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 16; i++) imem[i] = 16'hF000;
    endtask

    task automatic do_reset();
        start = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        im_lat = 0;
        dm_lat = 0;
        clear_stats();
    endtask

    task automatic run_prog(input int poke);
        int cyc;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        while (!stop && cyc < 500) begin
            @(negedge clk);
            cyc++;
            start = (poke > 0 && cyc == poke);
        end
        start = 1'b0;
        chk("run_reaches_stop", {31'h0, stop}, 32'h1);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        chk({tag, "_fetch_q_empty"}, exp_fetch_q.size(), 0);
        chk({tag, "_wr_q_empty"}, exp_wr_q.size(), 0);
        exp_fetch_q.delete();
        exp_wr_q.delete();
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        exp_dm = 8'h00;
        exp_rp = 4'h0;
        clear_stats();
        load_prog();

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_state", {28'h0, dbg_state}, {28'h0, ST_IDLE});
        chk("rst_stop", {31'h0, stop}, 32'h1);
        chk("rst_trap", {31'h0, trap}, 32'h0);
        chk("rst_strobes", {28'h0, im_rd, dm_rd, dm_wr, rf_w_wr}, 32'h0);
        chk("rst_addrs", {12'h0, im_addr, dm_addr, loac}, 32'h0);
        do_reset();

        // LDC r1,5; LDC r2,3; SUB r3,r1,r2; HALT with a redundant start mid-run
        load_prog();
        imem[0] = 16'h3105; imem[1] = 16'h3203; imem[2] = 16'h4312; imem[3] = 16'h6000;
        for (int i = 0; i < 4; i++) exp_fetch_q.push_back(4'(i));
        exp_wr_q.push_back(desc(4'd1, RF_SEL_LOAC, 2'b00, 8'h05, 1'b0, 4'h0, 1'b0, 4'h0));
        exp_wr_q.push_back(desc(4'd2, RF_SEL_LOAC, 2'b00, 8'h03, 1'b0, 4'h0, 1'b0, 4'h0));
        exp_wr_q.push_back(desc(4'd3, RF_SEL_ALU, ALU_SUB, 8'h00, 1'b1, 4'd1, 1'b1, 4'd2));
        run_prog(3);
        chk("prog1_pc", {28'h0, im_addr}, 32'h4);
        chk("prog1_state", {28'h0, dbg_state}, {28'h0, ST_HALT});
        chk("prog1_trap", {31'h0, trap}, 32'h0);
        drain("prog1");

        // LOAD r0,0x10 with ack after 3 waiting cycles
        do_reset();
        load_prog();
        imem[0] = 16'h0010; imem[1] = 16'h6000;
        dm_lat = 3; exp_dm = 8'h10;
        exp_fetch_q.push_back(4'd0); exp_fetch_q.push_back(4'd1);
        exp_wr_q.push_back(desc(4'd0, RF_SEL_DM, 2'b00, 8'h00, 1'b0, 4'h0, 1'b0, 4'h0));
        run_prog(2);
        chk("load_dm_rd_cycles", dm_rd_cyc, 4);
        chk("load_dm_addr", dm_addr_bad, 0);
        chk("load_wr_pulses", wr_pulses, 1);
        drain("load");

        // ADD rA,rB,rC; STORE r5,0x20 with one wait cycle
        do_reset();
        load_prog();
        imem[0] = 16'h2ABC; imem[1] = 16'h1520; imem[2] = 16'h6000;
        dm_lat = 1; exp_dm = 8'h20; exp_rp = 4'd5;
        for (int i = 0; i < 3; i++) exp_fetch_q.push_back(4'(i));
        exp_wr_q.push_back(desc(4'hA, RF_SEL_ALU, ALU_ADD, 8'h00, 1'b1, 4'hB, 1'b1, 4'hC));
        run_prog(0);
        chk("store_dm_wr_cycles", dm_wr_cyc, 2);
        chk("store_rp_port", store_bad, 0);
        chk("store_dm_addr", dm_addr_bad, 0);
        chk("store_no_dm_rd", dm_rd_cyc, 0);
        chk("store_pc", {28'h0, im_addr}, 32'h3);
        drain("store");

        // JMPZ r0,-3 at address 5 taken: PC after fetch is 6, target 6-3-1=2
        do_reset();
        load_prog();
        imem[0] = 16'h5005; imem[5] = 16'h50FD; imem[2] = 16'h6000;
        exp_fetch_q.push_back(4'd0); exp_fetch_q.push_back(4'd5); exp_fetch_q.push_back(4'd2);
        run_prog(0);
        chk("jmpz_taken_pc", {28'h0, im_addr}, 32'h3);
        drain("jmpz_taken");

        // same jump on r1, which is non-zero: falls through to 6
        do_reset();
        load_prog();
        imem[0] = 16'h5005; imem[5] = 16'h51FD; imem[6] = 16'h6000;
        exp_fetch_q.push_back(4'd0); exp_fetch_q.push_back(4'd5); exp_fetch_q.push_back(4'd6);
        run_prog(0);
        chk("jmpz_fall_pc", {28'h0, im_addr}, 32'h7);
        drain("jmpz_fall");

        // PC wrap: jump to 15, fetch at 15 wraps PC to 0, JMPZ +2 lands on 1
        do_reset();
        load_prog();
        imem[0] = 16'h500F; imem[15] = 16'h5002; imem[1] = 16'h6000;
        exp_fetch_q.push_back(4'd0); exp_fetch_q.push_back(4'd15); exp_fetch_q.push_back(4'd1);
        exp_pc_q.push_back(4'd1); exp_pc_q.push_back(4'd0); exp_pc_q.push_back(4'd2);
        pc_mon_en = 1'b1;
        run_prog(0);
        pc_mon_en = 1'b0;
        chk("wrap_pc_q_empty", exp_pc_q.size(), 0);
        chk("wrap_final_pc", {28'h0, im_addr}, 32'h2);
        drain("wrap");

        // every undefined opcode traps
        for (int op = 7; op < 16; op++) begin
            logic [3:0] opc;
            opc = 4'(op);
            do_reset();
            load_prog();
            imem[0] = {opc, 12'h000};
            exp_fetch_q.push_back(4'd0);
            run_prog(0);
            chk("illegal_trap", {28'h0, opc, trap}, {28'h0, opc, 1'b1});
            chk("illegal_state", {24'h0, opc, dbg_state}, {24'h0, opc, ST_TRAP});
        end
        drain("illegal");

        // start from TRAP restarts at PC 0
        imem[0] = 16'h6000;
        exp_fetch_q.push_back(4'd0);
        run_prog(0);
        chk("restart_trap_clear", {31'h0, trap}, 32'h0);
        chk("restart_pc", {28'h0, im_addr}, 32'h1);
        drain("restart");

        // data ack never arrives: trap after 15 strobe cycles
        do_reset();
        load_prog();
        imem[0] = 16'h0030;
        dm_lat = 255; exp_dm = 8'h30;
        exp_fetch_q.push_back(4'd0);
        run_prog(0);
        chk("dm_tmo_trap", {31'h0, trap}, 32'h1);
        chk("dm_tmo_cycles", dm_rd_cyc, 15);
        chk("dm_tmo_no_wr", wr_pulses, 0);
        drain("dm_tmo");

        // ack on the 15th cycle wins over the timeout
        do_reset();
        load_prog();
        imem[0] = 16'h0030; imem[1] = 16'h6000;
        dm_lat = 14; exp_dm = 8'h30;
        exp_fetch_q.push_back(4'd0); exp_fetch_q.push_back(4'd1);
        exp_wr_q.push_back(desc(4'd0, RF_SEL_DM, 2'b00, 8'h00, 1'b0, 4'h0, 1'b0, 4'h0));
        run_prog(0);
        chk("dm_late_ack_no_trap", {31'h0, trap}, 32'h0);
        chk("dm_late_ack_cycles", dm_rd_cyc, 15);
        chk("dm_late_ack_state", {28'h0, dbg_state}, {28'h0, ST_HALT});
        drain("dm_late");

        // instruction ack never arrives
        do_reset();
        load_prog();
        im_lat = 255;
        run_prog(0);
        chk("im_tmo_trap", {31'h0, trap}, 32'h1);
        chk("im_tmo_cycles", im_rd_cyc, 15);
        drain("im_tmo");

        // reset while a STORE waits for its ack
        do_reset();
        load_prog();
        imem[0] = 16'h1740;
        dm_lat = 255; exp_dm = 8'h40; exp_rp = 4'd7;
        exp_fetch_q.push_back(4'd0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        begin
            int cyc;
            cyc = 0;
            while (!dm_wr && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("mid_store_dm_wr", {31'h0, dm_wr}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_dm_wr", {31'h0, dm_wr}, 32'h0);
        chk("mid_rst_state", {28'h0, dbg_state}, {28'h0, ST_IDLE});
        chk("mid_rst_stop_trap", {30'h0, stop, trap}, 32'h2);
        chk("mid_rst_ctrl", {24'h0, im_rd, dm_rd, rf_rp_rd, rf_rq_rd, rf_w_wr, rf_s1, rf_s0, alu_s1},
            32'h0);
        chk("mid_rst_addrs", {4'h0, im_addr, dm_addr, rf_rp_addr, rf_w_addr, loac}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drain("mid_rst");
        chk("never_rd_and_wr", both_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
